// File: rtl/jesd204b_tx_pkg.sv
// Shared JESD204B TX definitions: control characters, link-mux encodings and
// the octet-generator FSM state type.
package jesd204b_tx_pkg;

  localparam int unsigned OCTET_W    = 8;
  localparam int unsigned MUX_W      = 3;
  localparam int unsigned F_W        = 8;
  localparam int unsigned K_W        = 5;
  localparam int unsigned MF_CNT_W   = 13;
  localparam int unsigned FK_W       = 14;
  localparam int unsigned MF_IDX_W   = 2;
  localparam int unsigned CFG_OCTETS = 14;
  localparam int unsigned CFG_W      = CFG_OCTETS * OCTET_W;

  localparam logic [OCTET_W-1:0] CHAR_K = 8'hBC;
  localparam logic [OCTET_W-1:0] CHAR_R = 8'h1C;
  localparam logic [OCTET_W-1:0] CHAR_A = 8'h7C;
  localparam logic [OCTET_W-1:0] CHAR_Q = 8'h9C;
  localparam logic [OCTET_W-1:0] CHAR_F = 8'hFC;

  localparam logic [MUX_W-1:0] SEND_USER_DATA = 3'd0;
  localparam logic [MUX_W-1:0] SEND_K         = 3'd1;
  localparam logic [MUX_W-1:0] SEND_LANE_SEQ  = 3'd2;

  typedef enum logic [1:0] {
    K_SEND   = 2'd0,
    ILA_WAIT = 2'd1,
    ILA      = 2'd2,
    DATA     = 2'd3
  } tx_state_e;

  // One encoder-bound character: octet plus control flag.
  typedef struct packed {
    logic                is_k;
    logic [OCTET_W-1:0]  data;
  } tx_char_t;

endpackage

// File: rtl/ila_seq_gen.sv
// Combinational ILA octet lookup from multiframe index, octet position within
// the multiframe, last multiframe position and the 14 link configuration octets.
module ila_seq_gen
  import jesd204b_tx_pkg::*;
(
  input  logic [MF_IDX_W-1:0] mf_idx,
  input  logic [MF_CNT_W-1:0] oct_in_mf,
  input  logic [MF_CNT_W-1:0] mf_last,
  input  logic [CFG_W-1:0]    cfg_octets,
  output tx_char_t            ila_char_c
);

  logic [3:0] cfg_idx;

  always_comb begin
    cfg_idx    = 4'(oct_in_mf - MF_CNT_W'(2));
    ila_char_c = '{is_k: 1'b0, data: oct_in_mf[OCTET_W-1:0]};
    if (oct_in_mf == '0) begin
      ila_char_c = '{is_k: 1'b1, data: CHAR_R};
    end else if (oct_in_mf == mf_last) begin
      ila_char_c = '{is_k: 1'b1, data: CHAR_A};
    end else if (mf_idx == MF_IDX_W'(1) && oct_in_mf == MF_CNT_W'(1)) begin
      ila_char_c = '{is_k: 1'b1, data: CHAR_Q};
    end else if (mf_idx == MF_IDX_W'(1) && oct_in_mf <= MF_CNT_W'(15)) begin
      // Positions 2..15 of the second multiframe carry config octets 0..13.
      ila_char_c = '{is_k: 1'b0, data: cfg_octets[{cfg_idx, 3'b000} +: OCTET_W]};
    end
  end

endmodule

// File: rtl/tx_octet_gen.sv
// Per-lane TX octet generator: /K/, ILA multiframes or user data toward the
// 8b/10b encoder. Optional character replacement under TX_CHAR_REPLACE_EN.
module tx_octet_gen
  import jesd204b_tx_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_clk,
  input  logic               lmfc_clk,
  input  logic [MUX_W-1:0]   i_link_mux,
  input  logic [F_W-1:0]     i_F,
  input  logic [K_W-1:0]     i_K,
  input  logic [OCTET_W-1:0] i_user_octet,
  input  logic [CFG_W-1:0]   i_cfg_octets,
  output logic               o_user_ready,
  output logic [OCTET_W-1:0] o_octet,
  output logic               o_is_k
);

  tx_state_e             state_q, state_d;
  logic [MF_IDX_W-1:0]   m_q, m_d;
  logic [F_W-1:0]        frm_q, oct_in_frame;
  logic [MF_CNT_W-1:0]   mf_q, oct_in_mf, mf_last;
  logic [FK_W-1:0]       fk;
  logic                  eof, eomf;
  tx_char_t              ila_char_c, data_char, out_d, out_q;

  assign o_user_ready = (i_link_mux == SEND_USER_DATA);

  // Position of the octet in the current cycle; strobes realign the counters.
  assign fk           = (FK_W'(i_F) + FK_W'(1)) * (FK_W'(i_K) + FK_W'(1));
  assign mf_last      = MF_CNT_W'(fk - FK_W'(1));
  assign oct_in_frame = frame_clk ? '0 : frm_q + F_W'(1);
  assign oct_in_mf    = lmfc_clk ? '0 : mf_q + MF_CNT_W'(1);
  assign eof          = (oct_in_frame == i_F);
  assign eomf         = (oct_in_mf == mf_last);

  // The decided state already governs the octet emitted this cycle.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    case (i_link_mux)
      SEND_USER_DATA: state_d = DATA;
      SEND_LANE_SEQ: begin
        if (state_q == ILA) begin
          if (lmfc_clk && m_q != MF_IDX_W'(2)) begin
            m_d = m_q + MF_IDX_W'(1);
          end
        end else if (lmfc_clk) begin
          state_d = ILA;
          m_d     = '0;
        end else begin
          state_d = ILA_WAIT;
        end
      end
      SEND_K:  state_d = K_SEND;
      default: state_d = K_SEND;
    endcase
  end

  ila_seq_gen u_ila_seq_gen (
    .mf_idx     (m_d),
    .oct_in_mf  (oct_in_mf),
    .mf_last    (mf_last),
    .cfg_octets (i_cfg_octets),
    .ila_char_c (ila_char_c)
  );

`ifdef TX_CHAR_REPLACE_EN
  logic [OCTET_W-1:0] hist_q;
  logic               hist_vld_q;

  // Compare against the original octet from the last end-of-frame in DATA.
  always_comb begin
    data_char = '{is_k: 1'b0, data: i_user_octet};
    if (hist_vld_q && i_user_octet == hist_q) begin
      if (eomf) begin
        data_char = '{is_k: 1'b1, data: CHAR_A};
      end else if (eof) begin
        data_char = '{is_k: 1'b1, data: CHAR_F};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
    end else if (state_d != DATA) begin
      hist_vld_q <= 1'b0;
    end else if (eof) begin
      hist_q     <= i_user_octet;
      hist_vld_q <= 1'b1;
    end
  end
`else
  logic unused_pos;

  assign data_char  = '{is_k: 1'b0, data: i_user_octet};
  assign unused_pos = eof ^ eomf;
`endif

  always_comb begin
    out_d = '{is_k: 1'b1, data: CHAR_K};
    case (state_d)
      ILA:     out_d = ila_char_c;
      DATA:    out_d = data_char;
      default: out_d = '{is_k: 1'b1, data: CHAR_K};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= K_SEND;
      m_q     <= '0;
      frm_q   <= '0;
      mf_q    <= '0;
      out_q   <= '{is_k: 1'b1, data: CHAR_K};
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      frm_q   <= oct_in_frame;
      mf_q    <= oct_in_mf;
      out_q   <= out_d;
    end
  end

  assign o_octet = out_q.data;
  assign o_is_k  = out_q.is_k;

endmodule

// File: tb/tb_tx_octet_gen.sv
// Scoreboard bench for tx_octet_gen; replacement expectations follow
// TX_CHAR_REPLACE_EN when it is defined.
module tb_tx_octet_gen;
  import jesd204b_tx_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_clk;
  logic         lmfc_clk;
  logic [2:0]   i_link_mux;
  logic [7:0]   i_F;
  logic [4:0]   i_K;
  logic [7:0]   i_user_octet;
  logic [111:0] i_cfg_octets;
  logic         o_user_ready;
  logic [7:0]   o_octet;
  logic         o_is_k;

  tx_octet_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_clk    (frame_clk),
    .lmfc_clk     (lmfc_clk),
    .i_link_mux   (i_link_mux),
    .i_F          (i_F),
    .i_K          (i_K),
    .i_user_octet (i_user_octet),
    .i_cfg_octets (i_cfg_octets),
    .o_user_ready (o_user_ready),
    .o_octet      (o_octet),
    .o_is_k       (o_is_k)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  cfg_ref[14];
  string       phase;

  // Reference model state; the bench owns the frame/multiframe timing.
  tx_state_e   m_st;
  int          m_mf;
  logic [7:0]  m_hist;
  bit          m_hvld;
  int          cyc;
  int          f_oct;
  int          k_frm;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [8:0] ila_ref(input int pos, input int mf, input int fk);
    if (pos == 0)                          return {1'b1, 8'h1C};
    if (pos == fk - 1)                     return {1'b1, 8'h7C};
    if (mf == 1 && pos == 1)               return {1'b1, 8'h9C};
    if (mf == 1 && pos >= 2 && pos <= 15)  return {1'b0, cfg_ref[pos-2]};
    return {1'b0, 8'(pos)};
  endfunction

  task automatic model_reset();
    m_st   = K_SEND;
    m_mf   = 0;
    m_hvld = 1'b0;
    m_hist = 8'h00;
  endtask

  // Drive one cycle, push its expected octet, then compare after the edge.
  task automatic step(input logic [2:0] mux, input logic [7:0] user);
    int         fk;
    int         pos_mf;
    int         pos_fr;
    logic [8:0] exp;
    logic [8:0] got;
    fk     = f_oct * k_frm;
    pos_mf = cyc % fk;
    pos_fr = cyc % f_oct;
    i_link_mux   = mux;
    i_user_octet = user;
    frame_clk    = (pos_fr == 0);
    lmfc_clk     = (pos_mf == 0);

    if (mux == 3'd0) begin
      m_st = DATA;
    end else if (mux == 3'd2) begin
      if (m_st == ILA) begin
        if (pos_mf == 0 && m_mf < 2) m_mf++;
      end else if (pos_mf == 0) begin
        m_st = ILA;
        m_mf = 0;
      end else begin
        m_st = ILA_WAIT;
      end
    end else begin
      m_st = K_SEND;
    end

    case (m_st)
      ILA:  exp = ila_ref(pos_mf, m_mf, fk);
      DATA: begin
        exp = {1'b0, user};
`ifdef TX_CHAR_REPLACE_EN
        if (m_hvld && user == m_hist) begin
          if (pos_mf == fk - 1)         exp = {1'b1, 8'h7C};
          else if (pos_fr == f_oct - 1) exp = {1'b1, 8'hFC};
        end
        if (pos_fr == f_oct - 1) begin
          m_hist = user;
          m_hvld = 1'b1;
        end
`endif
      end
      default: exp = {1'b1, 8'hBC};
    endcase
    if (m_st != DATA) m_hvld = 1'b0;
    exp_q.push_back(exp);

    #1;
    check({phase, ".ready"}, 9'(o_user_ready), 9'(mux == 3'd0));
    @(posedge clk);
    #1;
    got = {o_is_k, o_octet};
    check({phase, ".octet"}, got, exp_q.pop_front());
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 14; i++) begin
      cfg_ref[i] = 8'(32'h3A + i * 11);
      i_cfg_octets[8*i +: 8] = cfg_ref[i];
    end
    rst_n        = 1'b1;
    i_link_mux   = 3'd1;
    frame_clk    = 1'b0;
    lmfc_clk     = 1'b0;
    i_user_octet = 8'h00;
    i_F          = 8'd0;
    i_K          = 5'd19;
    f_oct        = 1;
    k_frm        = 20;
    cyc          = 0;
    model_reset();

    phase = "reset";
    #1 rst_n = 1'b0;
    #2;
    check("reset.octet", 9'(o_octet), 9'h0BC);
    check("reset.is_k",  9'(o_is_k), 9'h001);
    check("reset.ready", 9'(o_user_ready), 9'h000);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // F=1, K=20: idle /K/, then ILA requested mid-multiframe.
    phase = "k_send";
    repeat (25) step(3'd1, 8'($urandom));
    phase = "ila";
    repeat (75) step(3'd2, 8'($urandom));
    // Switch to user data exactly on a multiframe boundary.
    phase = "data";
    repeat (45) step(3'd0, 8'($urandom));
    phase = "k_gap";
    repeat (3) step(3'd7, 8'($urandom));

    // F=2, K=10: constant user octets exercise replacement at EoF/EoMF.
    i_F   = 8'd1;
    i_K   = 5'd9;
    f_oct = 2;
    k_frm = 10;
    cyc   = 0;
    phase = "k_cfg2";
    repeat (20) step(3'd1, 8'h55);
    phase = "repl";
    repeat (45) step(3'd0, 8'h55);

    // ILA interrupted by an out-of-range mux value, then restarted.
    phase = "ila_abort";
    repeat (20) step(3'd2, 8'($urandom));
    step(3'd5, 8'($urandom));
    phase = "ila_restart";
    repeat (30) step(3'd2, 8'($urandom));

    // Asynchronous reset in the middle of an ILA multiframe.
    phase = "async_rst";
    rst_n = 1'b0;
    #1;
    check("async_rst.octet", 9'(o_octet), 9'h0BC);
    check("async_rst.is_k",  9'(o_is_k), 9'h001);
    exp_q.delete();
    model_reset();
    #1 rst_n = 1'b1;

    phase = "post_rst";
    repeat (20) step(3'd1, 8'($urandom));
    phase = "post_rst_ila";
    repeat (25) step(3'd2, 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
